button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner_if.sv | 22 ++
 rtl/button_conditioner.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner_if.sv
// Button-side signal bundle for button_conditioner: raw bouncing inputs in,
// one-cycle counter pulses out.
interface button_conditioner_if;
    logic inc_raw;
    logic dec_raw;
    logic inc_btn;
    logic dec_btn;

    modport master (
        output inc_raw,
        output dec_raw,
        input  inc_btn,
        input  dec_btn
    );

    modport slave (
        input  inc_raw,
        input  dec_raw,
        output inc_btn,
        output dec_btn
    );
endinterface

// File: rtl/button_conditioner.sv
// Two-channel push-button conditioner: synchronize, debounce, press/auto-repeat pulses,
// cross-channel lockout. Auto-repeat is built only when BUTTON_AUTO_REPEAT_EN is defined.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  btn
);
    localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CNT = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;
`endif

    // Channel index 0 is increment, 1 is decrement.
    logic [1:0] raw_s;
    logic [1:0] press_s;
    logic [1:0] busy_s;
    logic       lock_r;
    logic       inc_r;
    logic       dec_r;
    logic       inc_nxt_s;
    logic       dec_nxt_s;

    assign raw_s = {btn.dec_raw, btn.inc_raw};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic          sync1_r;
        logic          sync2_r;
        logic          level_r;
        logic [CW-1:0] db_cnt_r;
        state_t        state_r;
        state_t        state_nxt_s;
        logic          pulse_s;
`ifdef BUTTON_AUTO_REPEAT_EN
        logic [CW-1:0] rpt_cnt_r;
        logic [CW-1:0] rpt_cnt_nxt_s;
`endif

        // Synchronizer and debounce: level flips only after a full run of differing samples
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync1_r  <= 1'b0;
                sync2_r  <= 1'b0;
                level_r  <= 1'b0;
                db_cnt_r <= '0;
            end else begin
                sync1_r <= raw_s[ch];
                sync2_r <= sync1_r;
                if (sync2_r == level_r) begin
                    db_cnt_r <= '0;
                end else if (db_cnt_r == DB_LAST) begin
                    level_r  <= sync2_r;
                    db_cnt_r <= '0;
                end else begin
                    db_cnt_r <= db_cnt_r + CNT_ONE;
                end
            end
        end

        // FSM state register
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_r   <= ST_IDLE;
`ifdef BUTTON_AUTO_REPEAT_EN
                rpt_cnt_r <= '0;
`endif
            end else begin
                state_r   <= state_nxt_s;
`ifdef BUTTON_AUTO_REPEAT_EN
                rpt_cnt_r <= rpt_cnt_nxt_s;
`endif
            end
        end

        // FSM next state; the repeat timer restarts on every state entry
        always_comb begin
            state_nxt_s = state_r;
`ifdef BUTTON_AUTO_REPEAT_EN
            rpt_cnt_nxt_s = '0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (level_r) state_nxt_s = ST_HELD;
                    else         state_nxt_s = ST_IDLE;
                end
                ST_HELD: begin
                    if (!level_r) begin
                        state_nxt_s = ST_IDLE;
`ifdef BUTTON_AUTO_REPEAT_EN
                    end else if (rpt_cnt_r == RD_LAST) begin
                        state_nxt_s = ST_REPEAT;
                    end else begin
                        state_nxt_s   = ST_HELD;
                        rpt_cnt_nxt_s = rpt_cnt_r + CNT_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (!level_r) begin
                        state_nxt_s = ST_IDLE;
                    end else if (rpt_cnt_r == RP_LAST) begin
                        state_nxt_s = ST_REPEAT;
                    end else begin
                        state_nxt_s   = ST_REPEAT;
                        rpt_cnt_nxt_s = rpt_cnt_r + CNT_ONE;
                    end
`else
                    end else begin
                        state_nxt_s = ST_HELD;
                    end
`endif
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end

        // Raw pulse request, decoded on the transitions that produce a pulse
        always_comb begin
            pulse_s = 1'b0;
            case (state_r)
                ST_IDLE:   pulse_s = level_r;
`ifdef BUTTON_AUTO_REPEAT_EN
                ST_HELD:   pulse_s = level_r && (rpt_cnt_r == RD_LAST);
                ST_REPEAT: pulse_s = level_r && (rpt_cnt_r == RP_LAST);
`else
                ST_HELD:   pulse_s = 1'b0;
`endif
                default:   pulse_s = 1'b0;
            endcase
        end

        assign press_s[ch] = pulse_s;
        assign busy_s[ch]  = (state_r != ST_IDLE);
    end

    // Arbitration: coincident requests cancel; a busy channel (or a latched
    // contention) silences the other until both are idle again
    always_comb begin
        inc_nxt_s = 1'b0;
        dec_nxt_s = 1'b0;
        if (press_s[0] && press_s[1]) begin
            inc_nxt_s = 1'b0;
            dec_nxt_s = 1'b0;
        end else begin
            inc_nxt_s = press_s[0] && !busy_s[1] && !(lock_r && busy_s[0]);
            dec_nxt_s = press_s[1] && !busy_s[0] && !(lock_r && busy_s[1]);
        end
    end

    // Registered output pulses and the contention latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_r  <= 1'b0;
            dec_r  <= 1'b0;
            lock_r <= 1'b0;
        end else begin
            inc_r <= inc_nxt_s;
            dec_r <= dec_nxt_s;
            if (!busy_s[0] && !busy_s[1]) begin
                lock_r <= 1'b0;
            end else if (busy_s[0] && busy_s[1]) begin
                lock_r <= 1'b1;
            end else begin
                lock_r <= lock_r;
            end
        end
    end

    assign btn.inc_btn = inc_r;
    assign btn.dec_btn = dec_r;
endmodule
